// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath.
// Valid/ready note: there is no handshake here. Every strobe is a level
// that is valid for the whole Clock cycle in which it is asserted, and
// IR/Strt/Stop are plain levels sampled by the sequencer.
interface control_sequencer_if #(
   parameter int OPW = 5
);
   logic [31:0]    IR;
   logic           Strt;
   logic           Stop;
   logic           PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
   logic           Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout;
   logic           Gra, Grb, Grc, Rin, Rout;
   logic [OPW-1:0] opcode;
   logic           Run;

   // Sequencer side: reads instruction and run requests, drives strobes.
   modport master (
      input  IR, Strt, Stop,
      output PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
      output Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout,
      output Gra, Grb, Grc, Rin, Rout, opcode, Run
   );

   // Datapath side: supplies IR and run requests, consumes strobes.
   modport slave (
      output IR, Strt, Stop,
      input  PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
      input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout,
      input  Gra, Grb, Grc, Rin, Rout, opcode, Run
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, per-class execute in T3-T6.
// Strobes are decoded combinationally from the current state and IR so
// that IR, loaded at the edge ending T2, can steer T3 in the same cycle.
// state_o exposes the FSM state for observation.
module control_sequencer #(
   parameter int OPW = 5
) (
   input  logic                 Clock,
   input  logic                 clear,
   control_sequencer_if.master  ctl,
   output logic [3:0]           state_o
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_AND  = 5'b01001;
   localparam logic [4:0] OP_OR   = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   state_t     state_q, state_d;
   logic [4:0] op;
   logic       is_rfmt, is_imm, is_md, is_un, is_halt;
   logic [4:0] alu_code;
   state_t     boundary;

   // Only the opcode field matters here; the rest belongs to the datapath.
   logic unused_ir;
   assign unused_ir = ^ctl.IR[26:0];

   assign op      = ctl.IR[31:27];
   assign state_o = state_q;

   // Instruction class decode and immediate-to-ALU opcode mapping.
   always_comb begin
      is_rfmt  = (op >= 5'b00011) && (op <= 5'b01010);
      is_imm   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
      is_md    = (op == OP_MUL) || (op == OP_DIV);
      is_un    = (op == OP_NEG) || (op == OP_NOT);
      is_halt  = (op == OP_HALT);
      alu_code = op;
      case (op)
         OP_ADDI: alu_code = OP_ADD;
         OP_ANDI: alu_code = OP_AND;
         OP_ORI:  alu_code = OP_OR;
         default: alu_code = op;
      endcase
   end

   // Next state; Stop is looked at only on an instruction boundary.
   always_comb begin
      boundary = ctl.Stop ? S_HALT : S_T0;
      state_d  = state_q;
      case (state_q)
         S_IDLE: state_d = ctl.Strt ? S_T0 : S_IDLE;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            if (is_rfmt || is_imm || is_md || is_un) state_d = S_T3;
            else if (is_halt)                       state_d = S_HALT;
            else                                    state_d = boundary;
         end
         S_T3:   state_d = S_T4;
         S_T4:   state_d = (is_rfmt || is_imm || is_md) ? S_T5 : boundary;
         S_T5:   state_d = is_md ? S_T6 : boundary;
         S_T6:   state_d = boundary;
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // State register; clear forces IDLE at once, abandoning any instruction.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Strobe decode from current state and IR; anything not named is 0.
   always_comb begin
      ctl.PCout    = 1'b0;
      ctl.PCin     = 1'b0;
      ctl.IncPC    = 1'b0;
      ctl.MARin    = 1'b0;
      ctl.Read     = 1'b0;
      ctl.MDRin    = 1'b0;
      ctl.MDRout   = 1'b0;
      ctl.IRin     = 1'b0;
      ctl.Yin      = 1'b0;
      ctl.Zin      = 1'b0;
      ctl.Zlowout  = 1'b0;
      ctl.Zhighout = 1'b0;
      ctl.HIin     = 1'b0;
      ctl.LOin     = 1'b0;
      ctl.Cout     = 1'b0;
      ctl.Gra      = 1'b0;
      ctl.Grb      = 1'b0;
      ctl.Grc      = 1'b0;
      ctl.Rin      = 1'b0;
      ctl.Rout     = 1'b0;
      ctl.opcode   = '0;
      ctl.Run      = (state_q != S_IDLE) && (state_q != S_HALT);
      case (state_q)
         S_T0: begin
            ctl.PCout = 1'b1;
            ctl.MARin = 1'b1;
            ctl.IncPC = 1'b1;
            ctl.Zin   = 1'b1;
         end
         S_T1: begin
            ctl.Zlowout = 1'b1;
            ctl.PCin    = 1'b1;
            ctl.Read    = 1'b1;
            ctl.MDRin   = 1'b1;
         end
         S_T2: begin
            ctl.MDRout = 1'b1;
            ctl.IRin   = 1'b1;
         end
         S_T3: begin
            if (is_rfmt || is_imm) begin
               ctl.Grb  = 1'b1;
               ctl.Rout = 1'b1;
               ctl.Yin  = 1'b1;
            end else if (is_md) begin
               ctl.Gra  = 1'b1;
               ctl.Rout = 1'b1;
               ctl.Yin  = 1'b1;
            end else if (is_un) begin
               ctl.Grb    = 1'b1;
               ctl.Rout   = 1'b1;
               ctl.Zin    = 1'b1;
               ctl.opcode = OPW'(alu_code);
            end
         end
         S_T4: begin
            if (is_rfmt) begin
               ctl.Grc    = 1'b1;
               ctl.Rout   = 1'b1;
               ctl.Zin    = 1'b1;
               ctl.opcode = OPW'(alu_code);
            end else if (is_imm) begin
               ctl.Cout   = 1'b1;
               ctl.Zin    = 1'b1;
               ctl.opcode = OPW'(alu_code);
            end else if (is_md) begin
               ctl.Grb    = 1'b1;
               ctl.Rout   = 1'b1;
               ctl.Zin    = 1'b1;
               ctl.opcode = OPW'(alu_code);
            end else if (is_un) begin
               ctl.Zlowout = 1'b1;
               ctl.Gra     = 1'b1;
               ctl.Rin     = 1'b1;
            end
         end
         S_T5: begin
            if (is_rfmt || is_imm) begin
               ctl.Zlowout = 1'b1;
               ctl.Gra     = 1'b1;
               ctl.Rin     = 1'b1;
            end else if (is_md) begin
               ctl.Zlowout = 1'b1;
               ctl.LOin    = 1'b1;
            end
         end
         S_T6: begin
            if (is_md) begin
               ctl.Zhighout = 1'b1;
               ctl.HIin     = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer with a tiny register-transfer
// datapath model so register results can be checked alongside strobes.
// IR field layout used by the model: op[31:27] ra[26:23] rb[22:19]
// rc[18:15] imm[18:0].
module tb_control_sequencer;

   logic       Clock;
   logic       clear;
   logic [3:0] dbg_state;

   control_sequencer_if #(.OPW(5)) sif ();

   control_sequencer #(.OPW(5)) dut (
      .Clock   (Clock),
      .clear   (clear),
      .ctl     (sif.master),
      .state_o (dbg_state)
   );

   // Clock
   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [3:0] ST_IDLE = 4'd0;
   localparam logic [3:0] ST_HALT = 4'd8;

   // Strobe bit masks, MSB to LSB in the order of the strobes vector.
   localparam logic [20:0] M_PCOUT  = 21'd1 << 20;
   localparam logic [20:0] M_PCIN   = 21'd1 << 19;
   localparam logic [20:0] M_INCPC  = 21'd1 << 18;
   localparam logic [20:0] M_MARIN  = 21'd1 << 17;
   localparam logic [20:0] M_READ   = 21'd1 << 16;
   localparam logic [20:0] M_MDRIN  = 21'd1 << 15;
   localparam logic [20:0] M_MDROUT = 21'd1 << 14;
   localparam logic [20:0] M_IRIN   = 21'd1 << 13;
   localparam logic [20:0] M_YIN    = 21'd1 << 12;
   localparam logic [20:0] M_ZIN    = 21'd1 << 11;
   localparam logic [20:0] M_ZLOW   = 21'd1 << 10;
   localparam logic [20:0] M_ZHIGH  = 21'd1 << 9;
   localparam logic [20:0] M_HIIN   = 21'd1 << 8;
   localparam logic [20:0] M_LOIN   = 21'd1 << 7;
   localparam logic [20:0] M_COUT   = 21'd1 << 6;
   localparam logic [20:0] M_GRA    = 21'd1 << 5;
   localparam logic [20:0] M_GRB    = 21'd1 << 4;
   localparam logic [20:0] M_GRC    = 21'd1 << 3;
   localparam logic [20:0] M_RIN    = 21'd1 << 2;
   localparam logic [20:0] M_ROUT   = 21'd1 << 1;
   localparam logic [20:0] M_RUN    = 21'd1;

   localparam logic [20:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
   localparam logic [20:0] E_T1 = M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN;
   localparam logic [20:0] E_T2 = M_MDROUT | M_IRIN | M_RUN;

   // Hand-encoded instructions.
   localparam logic [31:0] I_OR1  = 32'h5091_8000; // or   R1,R2,R3
   localparam logic [31:0] I_ADDI = 32'h5A10_0003; // addi R4,R2,3
   localparam logic [31:0] I_MUL  = 32'h7AB0_0000; // mul  R5,R6
   localparam logic [31:0] I_NEG  = 32'h8B90_0000; // neg  R7,R2
   localparam logic [31:0] I_NOP  = 32'hD000_0000; // nop
   localparam logic [31:0] I_UNK  = 32'hF800_0000; // opcode 11111
   localparam logic [31:0] I_OR8  = 32'h5411_8000; // or   R8,R2,R3
   localparam logic [31:0] I_OR9  = 32'h5491_8000; // or   R9,R2,R3
   localparam logic [31:0] I_HALT = 32'hD800_0000; // halt

   logic [20:0] strobes;
   assign strobes = {sif.PCout, sif.PCin, sif.IncPC, sif.MARin, sif.Read,
                     sif.MDRin, sif.MDRout, sif.IRin, sif.Yin, sif.Zin,
                     sif.Zlowout, sif.Zhighout, sif.HIin, sif.LOin, sif.Cout,
                     sif.Gra, sif.Grb, sif.Grc, sif.Rin, sif.Rout, sif.Run};

   // Datapath model: select-and-encode register file, Y, Z, HI, LO.
   logic [31:0] rf [16];
   logic [31:0] y_q, hi_q, lo_q, dbus;
   logic [63:0] z_q, alu;
   logic [3:0]  rsel;

   always_comb begin
      rsel = 4'd0;
      if (sif.Gra)      rsel = sif.IR[26:23];
      else if (sif.Grb) rsel = sif.IR[22:19];
      else if (sif.Grc) rsel = sif.IR[18:15];
      dbus = 32'd0;
      if (sif.Rout)          dbus = rf[rsel];
      else if (sif.Zlowout)  dbus = z_q[31:0];
      else if (sif.Zhighout) dbus = z_q[63:32];
      else if (sif.Cout)     dbus = {{13{sif.IR[18]}}, sif.IR[18:0]};
      alu = 64'd0;
      case (sif.opcode)
         5'b00011: alu = {32'd0, y_q + dbus};
         5'b00100: alu = {32'd0, y_q - dbus};
         5'b01001: alu = {32'd0, y_q & dbus};
         5'b01010: alu = {32'd0, y_q | dbus};
         5'b01111: alu = {32'd0, y_q} * {32'd0, dbus};
         5'b10001: alu = {32'd0, -dbus};
         5'b10010: alu = {32'd0, ~dbus};
         default:  alu = 64'd0;
      endcase
   end

   always @(posedge Clock) begin
      if (sif.Yin)  y_q  <= dbus;
      if (sif.Zin)  z_q  <= alu;
      if (sif.LOin) lo_q <= dbus;
      if (sif.HIin) hi_q <= dbus;
      if (sif.Rin)  rf[rsel] <= dbus;
   end

   // Scoreboard counters
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and compare strobes and opcode.
   task automatic expect_cycle(input string tag, input logic [20:0] exp_s, input logic [4:0] exp_op);
      @(negedge Clock);
      check({tag, ".strobes"}, 32'(strobes), 32'(exp_s));
      check({tag, ".opcode"}, 32'(sif.opcode), 32'(exp_op));
   endtask

   task automatic fetch_rest(input string tag);
      expect_cycle({tag, ".T1"}, E_T1, 5'd0);
      expect_cycle({tag, ".T2"}, E_T2, 5'd0);
   endtask

   // Driver / directed sequence
   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 32'd0;
      rf[2] = 32'd4;
      rf[3] = 32'd5;
      rf[5] = 32'h0001_0001;
      rf[6] = 32'h0003_0000;
      rf[9] = 32'h0000_0099;
      y_q = 32'd0; z_q = 64'd0; hi_q = 32'd0; lo_q = 32'd0;
      clear = 1'b1;
      sif.Strt = 1'b1;
      sif.Stop = 1'b0;
      sif.IR = I_OR1;
      #2 clear = 1'b0;
      #1;
      check("reset.async_state", 32'(dbg_state), 32'(ST_IDLE));
      for (int i = 0; i < 3; i++) begin
         expect_cycle("reset.hold", 21'd0, 5'd0);
         check("reset.hold_state", 32'(dbg_state), 32'(ST_IDLE));
      end
      clear = 1'b1;

      // or R1,R2,R3: T0 recurs 6 cycles after T0
      expect_cycle("or.T0", E_T0, 5'd0);
      sif.Strt = 1'b0;
      fetch_rest("or");
      expect_cycle("or.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'd0);
      expect_cycle("or.T4", M_GRC | M_ROUT | M_ZIN | M_RUN, 5'b01010);
      expect_cycle("or.T5", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'd0);
      expect_cycle("or.T0next", E_T0, 5'd0);
      check("or.R1", rf[1], 32'd5);

      // addi R4,R2,3: immediate through Cout, mapped to add
      sif.IR = I_ADDI;
      fetch_rest("addi");
      expect_cycle("addi.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'd0);
      expect_cycle("addi.T4", M_COUT | M_ZIN | M_RUN, 5'b00011);
      expect_cycle("addi.T5", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'd0);
      expect_cycle("addi.T0next", E_T0, 5'd0);
      check("addi.R4", rf[4], 32'd7);

      // mul R5,R6: LO in T5, HI in T6, 7 cycles total
      sif.IR = I_MUL;
      fetch_rest("mul");
      expect_cycle("mul.T3", M_GRA | M_ROUT | M_YIN | M_RUN, 5'd0);
      expect_cycle("mul.T4", M_GRB | M_ROUT | M_ZIN | M_RUN, 5'b01111);
      expect_cycle("mul.T5", M_ZLOW | M_LOIN | M_RUN, 5'd0);
      expect_cycle("mul.T6", M_ZHIGH | M_HIIN | M_RUN, 5'd0);
      expect_cycle("mul.T0next", E_T0, 5'd0);
      check("mul.LO", lo_q, 32'h0003_0000);
      check("mul.HI", hi_q, 32'h0000_0003);

      // neg R7,R2: 5 cycles total
      sif.IR = I_NEG;
      fetch_rest("neg");
      expect_cycle("neg.T3", M_GRB | M_ROUT | M_ZIN | M_RUN, 5'b10001);
      expect_cycle("neg.T4", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'd0);
      expect_cycle("neg.T0next", E_T0, 5'd0);
      check("neg.R7", rf[7], 32'hFFFF_FFFC);

      // nop and an unlisted opcode: 3 cycles each
      sif.IR = I_NOP;
      fetch_rest("nop");
      expect_cycle("nop.T0next", E_T0, 5'd0);
      sif.IR = I_UNK;
      fetch_rest("unk");
      expect_cycle("unk.T0next", E_T0, 5'd0);

      // Stop raised in T4: instruction completes, then HALT
      sif.IR = I_OR8;
      fetch_rest("stop");
      expect_cycle("stop.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'd0);
      expect_cycle("stop.T4", M_GRC | M_ROUT | M_ZIN | M_RUN, 5'b01010);
      sif.Stop = 1'b1;
      expect_cycle("stop.T5", M_ZLOW | M_GRA | M_RIN | M_RUN, 5'd0);
      for (int i = 0; i < 20; i++) expect_cycle("stop.halted", 21'd0, 5'd0);
      check("stop.state", 32'(dbg_state), 32'(ST_HALT));
      check("stop.R8", rf[8], 32'd5);
      sif.Stop = 1'b0;
      sif.Strt = 1'b1;
      expect_cycle("halt.sticky", 21'd0, 5'd0);
      expect_cycle("halt.sticky", 21'd0, 5'd0);
      check("halt.sticky_state", 32'(dbg_state), 32'(ST_HALT));

      // clear leaves HALT; then clear pulsed mid-T4 abandons the instruction
      clear = 1'b0;
      #1;
      check("clr_halt.state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge Clock);
      clear = 1'b1;
      sif.IR = I_OR9;
      expect_cycle("clr.T0", E_T0, 5'd0);
      sif.Strt = 1'b0;
      fetch_rest("clr");
      expect_cycle("clr.T3", M_GRB | M_ROUT | M_YIN | M_RUN, 5'd0);
      expect_cycle("clr.T4", M_GRC | M_ROUT | M_ZIN | M_RUN, 5'b01010);
      clear = 1'b0;
      #1;
      check("clr.async_strobes", 32'(strobes), 32'd0);
      check("clr.async_state", 32'(dbg_state), 32'(ST_IDLE));
      expect_cycle("clr.held", 21'd0, 5'd0);
      clear = 1'b1;
      expect_cycle("clr.idle", 21'd0, 5'd0);
      check("clr.idle_state", 32'(dbg_state), 32'(ST_IDLE));
      check("clr.R9_unchanged", rf[9], 32'h0000_0099);

      // halt instruction goes straight from T2 to HALT
      sif.IR = I_HALT;
      sif.Strt = 1'b1;
      expect_cycle("hlt.T0", E_T0, 5'd0);
      sif.Strt = 1'b0;
      fetch_rest("hlt");
      expect_cycle("hlt.after", 21'd0, 5'd0);
      check("hlt.state", 32'(dbg_state), 32'(ST_HALT));

      // Strt and Stop both high in IDLE: start anyway, halt at next boundary
      clear = 1'b0;
      #1 clear = 1'b1;
      sif.IR = I_NOP;
      sif.Strt = 1'b1;
      sif.Stop = 1'b1;
      expect_cycle("ss.T0", E_T0, 5'd0);
      sif.Strt = 1'b0;
      fetch_rest("ss");
      expect_cycle("ss.after", 21'd0, 5'd0);
      check("ss.state", 32'(dbg_state), 32'(ST_HALT));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
